// File: rtl/common.vh
// Shared sizing for the polynomial RAM datapath.
//   ADDR_WIDTH : RAM line address width
//   BIT_WIDTH  : bits per coefficient
//   LINE_SIZE  : coefficients per RAM line
`ifndef COMMON_VH
`define COMMON_VH
`define ADDR_WIDTH 8
`define BIT_WIDTH 16
`define LINE_SIZE 4
`endif

// File: rtl/poly_ram_reader.sv
// poly_ram_reader
// Streams `len` consecutive RAM lines starting at `base_addr` out of a
// 2-cycle-latency RAM port onto a valid/ready stream, with a small skid FIFO
// absorbing back-pressure.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   start, base_addr,len request (sampled only while idle)
//   ram_addr/ram_we/ram_en/ram_dout   RAM read port (data 2 cycles after addr)
//   out_data/out_valid/out_ready/out_last  output line stream
//   busy                 not idle
//   done                 one-cycle pulse after the final line transfers
`timescale 1ns/1ps
`include "common.vh"

module poly_ram_reader #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   start,
  input  logic [`ADDR_WIDTH-1:0]                 base_addr,
  input  logic [`ADDR_WIDTH:0]                   len,
  output logic [`ADDR_WIDTH-1:0]                 ram_addr,
  output logic                                   ram_we,
  output logic                                   ram_en,
  input  logic [`BIT_WIDTH*`LINE_SIZE-1:0]       ram_dout,
  output logic [`BIT_WIDTH*`LINE_SIZE-1:0]       out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   done
);

  localparam int AW = `ADDR_WIDTH;
  localparam int LW = `BIT_WIDTH * `LINE_SIZE;
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  generate
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadDepth
      $error("poly_ram_reader: FIFO_DEPTH must be a power of two >= 4");
    end
  endgenerate

  logic [1:0]    stateReg;
  logic [AW-1:0] addrReg;
  logic [AW:0]   lenReg;
  logic [AW:0]   issueCnt;
  logic [AW:0]   xferCnt;
  logic [AW:0]   lenMinus1;
  logic          tag1Reg;
  logic          tag2Reg;
  logic          doneReg;

  logic [PW:0]   wrPtr;
  logic [PW:0]   rdPtr;
  logic [PW:0]   fifoCount;
  logic          fifoEmpty;
  logic          fifoFull;
  logic [LW-1:0] fifoMem [FIFO_DEPTH];

  logic [PW+1:0] creditUsed;
  logic          issueFire;
  logic          lastIssue;
  logic          push;
  logic          pop;

  assign lenMinus1  = lenReg - {{AW{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifoCount  = wrPtr - rdPtr;
  assign fifoEmpty  = (wrPtr == rdPtr);
  assign fifoFull   = (fifoCount == (PW+1)'(FIFO_DEPTH));

  // Credit: every read in the 2-stage pipe already owns a FIFO slot, so the
  // FIFO can never be pushed while full no matter how long out_ready stalls.
  assign creditUsed = {1'b0, fifoCount} + (PW+2)'(tag1Reg) + (PW+2)'(tag2Reg);
  assign issueFire  = (stateReg == ISSUE) && (creditUsed < (PW+2)'(FIFO_DEPTH));
  assign lastIssue  = (issueCnt == lenMinus1);

  // The read tag leaves stage 2 exactly when its RAM data is on ram_dout.
  assign push       = tag2Reg;
  assign pop        = out_valid && out_ready;

  assign ram_addr   = addrReg;
  assign ram_we     = 1'b0;
  assign ram_en     = (stateReg != IDLE);
  assign busy       = (stateReg != IDLE);
  assign done       = doneReg;

  assign out_valid  = !fifoEmpty;
  assign out_data   = fifoMem[rdPtr[PW-1:0]];
  assign out_last   = !fifoEmpty && (stateReg != IDLE) && (xferCnt == lenMinus1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stateReg <= IDLE;
      addrReg  <= '0;
      lenReg   <= '0;
      issueCnt <= '0;
      doneReg  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              doneReg <= 1'b1;
            end else begin
              stateReg <= ISSUE;
              lenReg   <= len;
              addrReg  <= base_addr;
              issueCnt <= '0;
            end
          end
        end
        ISSUE: begin
          if (issueFire) begin
            if (lastIssue) begin
              // Keep ram_addr on the final address for the drain phase.
              stateReg <= DRAIN;
            end else begin
              addrReg  <= addrReg + 1'b1;   // wraps modulo 2^AW
              issueCnt <= issueCnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (pop && out_last) begin
            stateReg <= IDLE;
            doneReg  <= 1'b1;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  // Transfer counter drives out_last; it restarts with every accepted request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xferCnt <= '0;
    end else if (stateReg == IDLE && start) begin
      xferCnt <= '0;
    end else if (pop) begin
      xferCnt <= xferCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag1Reg <= 1'b0;
      tag2Reg <= 1'b0;
      wrPtr   <= '0;
      rdPtr   <= '0;
    end else begin
      tag1Reg <= issueFire;
      tag2Reg <= tag1Reg;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone decide what is visible.
  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr[PW-1:0]] <= ram_dout;
  end

  aPushFull: assert property (@(posedge clk) disable iff (!rstn) !(push && fifoFull));
  aPopEmpty: assert property (@(posedge clk) disable iff (!rstn) !(pop && fifoEmpty));
  aCredit:   assert property (@(posedge clk) disable iff (!rstn)
                              creditUsed <= (PW+2)'(FIFO_DEPTH));

endmodule

// File: tb/tb_poly_ram_reader.sv
`timescale 1ns/1ps
`include "common.vh"

module tb_poly_ram_reader;

  localparam int AW    = `ADDR_WIDTH;
  localparam int LW    = `BIT_WIDTH * `LINE_SIZE;
  localparam int NADDR = 1 << AW;

  logic          clk;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_en;
  logic [LW-1:0] ram_dout;
  logic [LW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  poly_ram_reader #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .len(len),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_en(ram_en), .ram_dout(ram_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: address register then output register gated by ram_en.
  logic [LW-1:0] ramMem [NADDR];
  logic [AW-1:0] ramAddrQ;
  always @(posedge clk) begin
    ramAddrQ <= ram_addr;
    if (ram_en) ram_dout <= ramMem[ramAddrQ];
  end

  typedef struct packed {
    logic [LW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sbQ[$];
  int   nCompared;
  int   nMismatched;
  int   xferCount;
  int   holdLow;
  bit   randReady;
  bit   len0Pending;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a request of len lines is the RAM contents at base+k mod 2^AW.
  task automatic pushExpect(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.data = ramMem[(base + k) % NADDR];
      e.last = (k == n - 1);
      sbQ.push_back(e);
    end
  endtask

  // Monitor / scoreboard
  bit            expDone;
  bit            prevStall;
  logic [LW-1:0] stallData;
  always @(negedge clk) begin
    if (!rstn) begin
      expDone   = 1'b0;
      prevStall = 1'b0;
    end else begin
      chk("done", 128'(done), 128'(expDone));
      expDone = 1'b0;
      if (len0Pending) begin
        expDone     = 1'b1;
        len0Pending = 1'b0;
      end
      if (prevStall) begin
        chk("stall_valid", 128'(out_valid), 128'(1'b1));
        chk("stall_data", 128'(out_data), 128'(stallData));
      end
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          chk("unexpected_xfer", 128'(out_data), 128'(0));
          if (out_data == '0) begin
            nMismatched++;
            $display("FAIL unexpected_xfer: got line with no expectation (t=%0t)", $time);
          end
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          chk("data", 128'(out_data), 128'(e.data));
          chk("last", 128'(out_last), 128'(e.last));
          $display("xfer %0d data=%0h last=%0b", xferCount, out_data, out_last);
          if (e.last) expDone = 1'b1;
        end
        xferCount++;
      end
      prevStall = out_valid && !out_ready;
      stallData = out_data;
    end
  end

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (holdLow > 0) begin
        out_ready = 1'b0;
        holdLow--;
      end else if (randReady) begin
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic doStart(input int base, input int n, input bit expectIt);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = AW'(base);
    len       = (AW+1)'(n);
    if (expectIt) begin
      if (n == 0) len0Pending = 1'b1;
      else        pushExpect(base, n);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while ((busy || sbQ.size() != 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= budget) begin
      nMismatched++;
      $display("FAIL timeout: busy=%0b pending=%0d after %0d cycles", busy, sbQ.size(), cyc);
    end
    chk("sb_empty", 128'(sbQ.size()), 128'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic chkResetOutputs();
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_last", 128'(out_last), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_en", 128'(ram_en), 128'(0));
    chk("rst_we", 128'(ram_we), 128'(0));
    chk("rst_addr", 128'(ram_addr), 128'(0));
  endtask

  initial begin
    nCompared = 0; nMismatched = 0; xferCount = 0;
    holdLow = 0; randReady = 1'b0; len0Pending = 1'b0;
    start = 1'b0; base_addr = '0; len = '0;
    ram_dout = '0;
    for (int a = 0; a < NADDR; a++) begin
      logic [LW-1:0] v;
      for (int b = 0; b < LW; b++) v[b] = 1'($urandom_range(0, 1));
      ramMem[a] = v;
    end

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chkResetOutputs();
    @(posedge clk); #1; rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Scenario: base 0x10, len 8, ready high -- exact timing.
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(8'h10); len = (AW+1)'(8);
    pushExpect(16, 8);
    @(negedge clk);
    chk("s1_en_t0", 128'(ram_en), 128'(0));
    chk("s1_busy_t0", 128'(busy), 128'(0));
    @(posedge clk); #1; start = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      if (t <= 8) begin
        chk("s1_addr", 128'(ram_addr), 128'(16 + t - 1));
        chk("s1_en", 128'(ram_en), 128'(1));
      end
      if (t == 3) chk("s1_first_latency", 128'(out_valid), 128'(0));
      if (t >= 4 && t <= 11) begin
        chk("s1_valid", 128'(out_valid), 128'(1));
        chk("s1_last", 128'(out_last), 128'(t == 11));
      end
      if (t == 12) begin
        chk("s1_done", 128'(done), 128'(1));
        chk("s1_busy_end", 128'(busy), 128'(0));
      end
      chk("s1_we", 128'(ram_we), 128'(0));
    end
    waitIdle(100);

    // Scenario: address wrap, base = max-1, len 4.
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(NADDR - 2); len = (AW+1)'(4);
    pushExpect(NADDR - 2, 4);
    @(posedge clk); #1; start = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      chk("wrap_addr", 128'(ram_addr), 128'((NADDR - 2 + t - 1) % NADDR));
    end
    waitIdle(100);

    // Scenario: len 0 -> done next cycle, nothing else moves.
    doStart(5, 0, 1'b1);
    @(negedge clk);
    chk("len0_busy", 128'(busy), 128'(0));
    chk("len0_en", 128'(ram_en), 128'(0));
    chk("len0_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    chk("len0_done_clear", 128'(done), 128'(0));
    waitIdle(20);

    // Scenario: len 6 with random ready and a 10-cycle stall.
    randReady = 1'b1;
    doStart(int'($urandom_range(0, NADDR - 1)), 6, 1'b1);
    repeat (3) @(posedge clk);
    holdLow = 10;
    waitIdle(300);

    // Scenario: second start while busy is ignored.
    randReady = 1'b0;
    doStart(8'h20, 5, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(8'h80); len = (AW+1)'(3);
    @(negedge clk);
    chk("busy_during", 128'(busy), 128'(1));
    @(posedge clk); #1; start = 1'b0;
    waitIdle(100);

    // Scenario: reset dropped at the 3rd transfer, then base 0x40 len 2.
    begin
      int x0;
      int cyc;
      x0 = xferCount;
      doStart(int'($urandom_range(0, NADDR - 1)), 8, 1'b1);
      cyc = 0;
      while (xferCount < x0 + 2 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 100) begin
        nMismatched++;
        $display("FAIL timeout: reset scenario saw %0d transfers", xferCount - x0);
      end
      @(negedge clk);
      #2;
      rstn = 1'b0;
      sbQ.delete();
      @(negedge clk);
      chkResetOutputs();
      repeat (2) @(negedge clk);
      @(posedge clk); #1; rstn = 1'b1;
      doStart(8'h40, 2, 1'b1);
      waitIdle(100);
    end

    // Random requests with random back-pressure.
    randReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      doStart(int'($urandom_range(0, NADDR - 1)), int'($urandom_range(1, 12)), 1'b1);
      waitIdle(400);
    end

    // Whole RAM in one request.
    randReady = 1'b0;
    doStart(int'($urandom_range(0, NADDR - 1)), NADDR, 1'b1);
    waitIdle(NADDR * 4 + 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
